// File: rtl/capture_buffer_ctrl.sv
// Triggered capture-buffer sequencer: circular pre/post-trigger writes on RAM port A,
// then an oldest-first dump of the frozen buffer through port B onto a valid/ready stream.
module capture_buffer_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] post_count,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic                  ram_en_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic                  ram_en_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [ADDR_WIDTH:0]   dump_len,
  output logic [1:0]            state,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DUMP    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] post_rem_q, post_rem_d;
  logic [ADDR_WIDTH:0]   dump_len_q, dump_len_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic                  done_q, done_d;

  logic                  wa_en_q, wa_en_d;
  logic [ADDR_WIDTH-1:0] wa_addr_q, wa_addr_d;
  logic [DATA_WIDTH-1:0] wa_din_q, wa_din_d;

  logic                  pend_q, pend_last_q;
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  logic [1:0]            sk_cnt_q;
  logic                  sk_wr_q, sk_rd_q;
  logic [1:0]            sk_last_q;
  logic [DATA_WIDTH-1:0] sk_data [2];

  logic                  accept;
  logic                  enter_dump;
  logic                  issue;
  logic                  issue_last;
  logic                  byp;
  logic                  pop;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic [2:0]            occ;

  assign pop       = m_valid & m_ready;
  assign push      = pend_q;
  assign push_data = byp_q ? byp_data_q : ram_dout_b;

  // Reads in flight plus words held must never exceed the two skid slots.
  assign occ        = {1'b0, sk_cnt_q} + {2'b00, pend_q} - {2'b00, pop};
  assign issue      = (state_q == ST_DUMP) && (rd_cnt_q != dump_len_q) && (occ < 3'd2);
  assign issue_last = (rd_cnt_q == dump_len_q - 1'b1);
  // The final capture write may still sit in the port A register when the first read
  // hits the same address, so that word is forwarded instead of read from the RAM.
  assign byp        = issue && wa_en_q && (wa_addr_q == rd_addr_q);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    post_rem_d = post_rem_q;
    dump_len_d = dump_len_q;
    rd_addr_d  = rd_addr_q;
    rd_cnt_d   = rd_cnt_q;
    done_d     = 1'b0;
    wa_en_d    = 1'b0;
    wa_addr_d  = wa_addr_q;
    wa_din_d   = wa_din_q;
    enter_dump = 1'b0;

    accept = s_valid && ((state_q == ST_CAPTURE) || (state_q == ST_POST));
    if (accept) begin
      wa_en_d   = 1'b1;
      wa_addr_d = wr_ptr_q;
      wa_din_d  = s_data;
      wr_ptr_d  = wr_ptr_q + 1'b1;
      if (fill_q != DEPTH_V) begin
        fill_d = fill_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d  = ST_CAPTURE;
          wr_ptr_d = '0;
          fill_d   = '0;
        end
      end
      ST_CAPTURE: begin
        if (trigger) begin
          if (post_count == '0) begin
            enter_dump = 1'b1;
          end else begin
            state_d    = ST_POST;
            post_rem_d = post_count;
          end
        end
      end
      ST_POST: begin
        if (s_valid) begin
          post_rem_d = post_rem_q - 1'b1;
          if (post_rem_q == {{(ADDR_WIDTH-1){1'b0}}, 1'b1}) begin
            enter_dump = 1'b1;
          end
        end
      end
      ST_DUMP: begin
        if (issue) begin
          rd_addr_d = rd_addr_q + 1'b1;
          rd_cnt_d  = rd_cnt_q + 1'b1;
        end
        if (dump_len_q == '0 || (pop && m_last)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Start from the oldest surviving sample: wr_ptr once the ring has wrapped, else 0.
    if (enter_dump) begin
      state_d    = ST_DUMP;
      dump_len_d = fill_d;
      rd_addr_d  = (fill_d == DEPTH_V) ? wr_ptr_d : '0;
      rd_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      post_rem_q  <= '0;
      dump_len_q  <= '0;
      rd_addr_q   <= '0;
      rd_cnt_q    <= '0;
      done_q      <= 1'b0;
      wa_en_q     <= 1'b0;
      wa_addr_q   <= '0;
      wa_din_q    <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      byp_q       <= 1'b0;
      byp_data_q  <= '0;
      sk_cnt_q    <= '0;
      sk_wr_q     <= 1'b0;
      sk_rd_q     <= 1'b0;
      sk_last_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      post_rem_q  <= post_rem_d;
      dump_len_q  <= dump_len_d;
      rd_addr_q   <= rd_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      done_q      <= done_d;
      wa_en_q     <= wa_en_d;
      wa_addr_q   <= wa_addr_d;
      wa_din_q    <= wa_din_d;
      pend_q      <= issue;
      pend_last_q <= issue && issue_last;
      byp_q       <= byp;
      byp_data_q  <= wa_din_q;
      sk_cnt_q    <= sk_cnt_q + {1'b0, push} - {1'b0, pop};
      sk_wr_q     <= sk_wr_q ^ push;
      sk_rd_q     <= sk_rd_q ^ pop;
      if (push) begin
        sk_last_q[sk_wr_q] <= pend_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sk_data[sk_wr_q] <= push_data;
    end
  end

  assign ram_en_a   = wa_en_q;
  assign ram_we_a   = wa_en_q;
  assign ram_addr_a = wa_addr_q;
  assign ram_din_a  = wa_din_q;
  assign ram_en_b   = issue;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_addr_q;

  assign m_valid  = (sk_cnt_q != 2'd0);
  assign m_data   = m_valid ? sk_data[sk_rd_q] : '0;
  assign m_last   = m_valid & sk_last_q[sk_rd_q];
  assign dump_len = dump_len_q;
  assign state    = state_q;
  assign done     = done_q;

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Scoreboard bench for capture_buffer_ctrl with a behavioural dual-port RAM beside it.
module tb_capture_buffer_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid, arm, trigger;
  logic [AW-1:0] post_count;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_dout_b;
  logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready, m_last;
  logic [AW:0]   dump_len;
  logic [1:0]    state;
  logic          done;

  always #5 clk = ~clk;

  capture_buffer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .arm(arm),
    .trigger(trigger), .post_count(post_count), .ram_addr_a(ram_addr_a),
    .ram_din_a(ram_din_a), .ram_en_a(ram_en_a), .ram_we_a(ram_we_a),
    .ram_addr_b(ram_addr_b), .ram_en_b(ram_en_b), .ram_we_b(ram_we_b),
    .ram_dout_b(ram_dout_b), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .dump_len(dump_len), .state(state), .done(done)
  );

  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (ram_en_a && ram_we_a) ram[ram_addr_a] <= ram_din_a;
    if (ram_en_b) ram_dout_b <= ram[ram_addr_b];
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            failures = 0;
  int            pops = 0;
  int            mv_seen = 0;
  int            ready_mode = 1;
  int            stop_at = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (m_valid) mv_seen++;
        if (stall_prev) begin
          check("stall_valid", {31'd0, m_valid}, 32'd1);
          check("stall_data", {16'd0, m_data}, {16'd0, held_d});
          check("stall_last", {31'd0, m_last}, {31'd0, held_l});
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_word: got %0h expected no word", m_data);
          end else begin
            mon_e = exp_q.pop_front();
            check("dump_data", {16'd0, m_data}, {16'd0, mon_e.d});
            check("dump_last", {31'd0, m_last}, {31'd0, mon_e.l});
            $display("word data=%0d last=%0b", m_data, m_last);
          end
          pops++;
        end
        stall_prev = m_valid && !m_ready;
        held_d     = m_data;
        held_l     = m_last;
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        2:       m_ready = ($urandom_range(0, 1) == 1);
        default: m_ready = (pops < stop_at);
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v);
    s_data  = v;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic trig(input logic [AW-1:0] pc);
    trigger    = 1'b1;
    post_count = pc;
    step();
    trigger    = 1'b0;
  endtask

  task automatic expect_word(input logic [DW-1:0] v, input logic l);
    exp_t x;
    x.d = v;
    x.l = l;
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input string name, input int budget, input int max_dump);
    int n    = 0;
    int dcyc = 0;
    bit got  = 1'b0;
    while (n < budget && !got) begin
      @(negedge clk);
      n++;
      if (state == 2'd3) dcyc++;
      if (done) got = 1'b1;
    end
    check({name, "_done_seen"}, {31'd0, got}, 32'd1);
    check({name, "_dump_cycles_ok"}, {31'd0, (dcyc <= max_dump)}, 32'd1);
    @(negedge clk);
    check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({name, "_words_left"}, exp_q.size(), 32'd0);
    step();
  endtask

  task automatic capture_40();
    arm_pulse();
    for (int i = 0; i < 40; i++) send(DW'(i));
    for (int i = 24; i < 40; i++) expect_word(DW'(i), i == 39);
    trig('0);
    check("wrap_state", {30'd0, state}, 32'd3);
    check("wrap_dump_len", {27'd0, dump_len}, 32'd16);
  endtask

  initial begin
    int n;
    int base;
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; arm = 1'b0; trigger = 1'b0; post_count = '0;
    repeat (3) step();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_dump_len", {27'd0, dump_len}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_en_a", {30'd0, ram_en_a, ram_we_a}, 32'd0);
    check("rst_en_b", {30'd0, ram_en_b, ram_we_b}, 32'd0);
    check("rst_addr", {24'd0, ram_addr_a, ram_addr_b}, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic pre/post capture, 8 words.
    for (int i = 0; i < 8; i++) expect_word(DW'(i), i == 7);
    arm_pulse();
    check("arm_state", {30'd0, state}, 32'd1);
    for (int i = 0; i < 5; i++) send(DW'(i));
    trig(4'd3);
    check("post_state", {30'd0, state}, 32'd2);
    for (int i = 5; i < 8; i++) send(DW'(i));
    check("basic_state", {30'd0, state}, 32'd3);
    check("basic_dump_len", {27'd0, dump_len}, 32'd8);
    wait_done("basic", 40, 11);

    // Wrapped buffer, ready high then random ready.
    capture_40();
    wait_done("wrap", 40, 19);
    ready_mode = 2;
    capture_40();
    wait_done("wrap_rand", 300, 300);
    ready_mode = 1;

    // Trigger/s_valid in IDLE, then arm/trigger/s_valid during DUMP.
    s_valid = 1'b1; trigger = 1'b1; s_data = 16'd77;
    step();
    s_valid = 1'b0; trigger = 1'b0;
    check("idle_trig_state", {30'd0, state}, 32'd0);
    check("idle_no_write", {31'd0, ram_we_a}, 32'd0);
    arm_pulse();
    send(16'd50); send(16'd51); send(16'd52);
    expect_word(16'd50, 1'b0); expect_word(16'd51, 1'b0); expect_word(16'd52, 1'b1);
    ready_mode = 0;
    trig('0);
    step(); step();
    arm = 1'b1; trigger = 1'b1; s_valid = 1'b1; s_data = 16'd99;
    step();
    arm = 1'b0; trigger = 1'b0; s_valid = 1'b0;
    check("dump_ignore_state", {30'd0, state}, 32'd3);
    check("dump_no_write", {31'd0, ram_we_a}, 32'd0);
    check("dump_ignore_len", {27'd0, dump_len}, 32'd3);
    ready_mode = 1;
    wait_done("ignore", 40, 40);

    // Empty capture: arm then immediate trigger with post_count=0.
    base = mv_seen;
    arm_pulse();
    trig('0);
    wait_done("empty", 2, 2);
    check("empty_no_valid", mv_seen, base);
    check("empty_dump_len", {27'd0, dump_len}, 32'd0);

    // Reset after 3 dumped words, then a fresh capture.
    arm_pulse();
    for (int i = 0; i < 10; i++) send(DW'(100 + i));
    for (int i = 0; i < 10; i++) expect_word(DW'(100 + i), i == 9);
    base    = pops;
    stop_at = pops + 3;
    ready_mode = 3;
    trig('0);
    n = 0;
    while (pops < stop_at && n < 50) begin
      step();
      n++;
    end
    check("abort_words", pops - base, 32'd3);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_state", {30'd0, state}, 32'd0);
    check("abort_valid_last_done", {29'd0, m_valid, m_last, done}, 32'd0);
    check("abort_m_data", {16'd0, m_data}, 32'd0);
    check("abort_dump_len", {27'd0, dump_len}, 32'd0);
    check("abort_ram_ctl", {28'd0, ram_en_a, ram_we_a, ram_en_b, ram_we_b}, 32'd0);
    step();
    rst_n = 1'b1;
    ready_mode = 1;
    step();
    arm_pulse();
    for (int i = 0; i < 5; i++) send(DW'(200 + i));
    for (int i = 0; i < 5; i++) expect_word(DW'(200 + i), i == 4);
    trig('0);
    check("fresh_dump_len", {27'd0, dump_len}, 32'd5);
    wait_done("fresh", 40, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
